// File: rtl/vram_access_ctrl_pkg.sv
// Shared constants, register codes, write-FSM states and the fetch-address helper
// for the name-table access controller.
package vram_access_ctrl_pkg;

  localparam int unsigned CELLS = 1200;
  localparam int unsigned COLS  = 40;
  localparam int unsigned ROWS  = 30;

  localparam logic [1:0] CPU_REG_DATA = 2'd0;
  localparam logic [1:0] CPU_REG_LO   = 2'd1;
  localparam logic [1:0] CPU_REG_HI   = 2'd2;
  localparam logic [1:0] CPU_REG_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } wr_state_t;

  // row*40 + col without a multiplier
  function automatic logic [10:0] fetch_addr(input logic [4:0] row, input logic [5:0] col);
    return ({6'd0, row} << 5) + ({6'd0, row} << 3) + {5'd0, col};
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO holding queued CPU name-table writes as {addr, data}.
// Full flag is registered and reflects the occupancy after each cycle's push/pop.
module vram_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full_r;
  assign do_pop_s  = pop && (count_r != CW'(0));

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointer, occupancy and full-flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      full_r   <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = (count_r == CW'(0));
  assign count = count_r;

endmodule

// File: rtl/vram_access_ctrl.sv
// Arbitrates the name-table RAM port between display tile fetch and queued CPU
// writes, which are only drained during blanking; also owns the CPU cursor.
module vram_access_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned WR_LAST_HPOS = 795,
  parameter int unsigned CELLS        = 1200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_on,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_reg,
  input  logic [7:0]  cpu_data,
  output logic        cpu_full,
  output logic        cpu_overflow,
  output logic [10:0] cpu_cursor,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we
);

  import vram_access_ctrl_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [10:0] LAST_CELL_C = 11'(CELLS - 1);
  localparam logic [10:0] CELLS_C     = 11'(CELLS);
  localparam logic [9:0]  WR_LAST_C   = 10'(WR_LAST_HPOS);

  wr_state_t        state_r;
  logic [10:0]      cursor_r;
  logic             overflow_r;
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [18:0]      fifo_head_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [10:0]      cursor_lo_s;
  logic [10:0]      cursor_hi_s;
  logic [10:0]      fetch_addr_s;
  logic             cell_start_s;
  logic             wr_window_s;
  logic             unused_s;

  assign fifo_push_s  = cpu_wr && (cpu_reg == CPU_REG_DATA) && !fifo_full_s;
  assign fifo_pop_s   = (state_r == ST_HOLD);
  assign cursor_lo_s  = {cursor_r[10:8], cpu_data};
  assign cursor_hi_s  = {cpu_data[2:0], cursor_r[7:0]};
  assign fetch_addr_s = fetch_addr(vpos[8:4], hpos[9:4]);
  assign cell_start_s = display_on && (hpos[3:0] == 4'd0);
  // Last start point keeps the 3-cycle write clear of the next line's first fetch
  assign wr_window_s  = !fifo_empty_s && !display_on && (hpos <= WR_LAST_C);
  assign unused_s     = ^{vpos[9], vpos[3:0], fifo_count_s};

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (19)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push_s),
    .pop     (fifo_pop_s),
    .wdata   ({cursor_r, cpu_data}),
    .rdata   (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // CPU register writes: cursor update and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cursor_r   <= 11'd0;
      overflow_r <= 1'b0;
    end else if (cpu_wr) begin
      case (cpu_reg)
        CPU_REG_DATA: begin
          if (!fifo_full_s) cursor_r <= (cursor_r == LAST_CELL_C) ? 11'd0 : cursor_r + 11'd1;
          else              overflow_r <= 1'b1;
        end
        CPU_REG_LO: cursor_r <= (cursor_lo_s >= CELLS_C) ? 11'd0 : cursor_lo_s;
        CPU_REG_HI: cursor_r <= (cursor_hi_s >= CELLS_C) ? 11'd0 : cursor_hi_s;
        default: cursor_r <= cursor_r;
      endcase
    end
  end

  // Write FSM and registered RAM port; fetch address always takes precedence
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      ram_addr <= 11'd0;
      ram_din  <= 8'd0;
      ram_we   <= 1'b0;
    end else begin
      if (cell_start_s) ram_addr <= fetch_addr_s;
      case (state_r)
        ST_IDLE: begin
          ram_we <= 1'b0;
          if (wr_window_s) begin
            state_r  <= ST_SETUP;
            ram_addr <= fifo_head_s[18:8];
            ram_din  <= fifo_head_s[7:0];
          end
        end
        ST_SETUP: begin
          if (display_on) begin
            state_r <= ST_IDLE;
            ram_we  <= 1'b0;
          end else begin
            state_r <= ST_STROBE;
            ram_we  <= 1'b1;
          end
        end
        ST_STROBE: begin
          state_r <= ST_HOLD;
          ram_we  <= 1'b0;
        end
        ST_HOLD: begin
          state_r <= ST_IDLE;
          ram_we  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ram_we  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_cursor   = cursor_r;
  assign cpu_overflow = overflow_r;
  assign cpu_full     = fifo_full_s;

endmodule

// File: tb/tb_vram_access_ctrl.sv
// Directed bench for vram_access_ctrl: drives raster position and CPU writes,
// models the RAM behind the port and checks hand-computed results.
module tb_vram_access_ctrl;

  localparam logic [1:0] R_DATA = 2'd0;
  localparam logic [1:0] R_LO   = 2'd1;
  localparam logic [1:0] R_HI   = 2'd2;
  localparam logic [1:0] R_RSVD = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  hpos = 10'd0;
  logic [9:0]  vpos = 10'd0;
  logic        display_on = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [1:0]  cpu_reg = 2'd0;
  logic [7:0]  cpu_data = 8'd0;
  logic        cpu_full;
  logic        cpu_overflow;
  logic [10:0] cpu_cursor;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_model [0:1199];
  logic       model_init_r = 1'b0;
  int         wr_count = 0;
  int         disp_viol = 0;

  vram_access_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hpos         (hpos),
    .vpos         (vpos),
    .display_on   (display_on),
    .cpu_wr       (cpu_wr),
    .cpu_reg      (cpu_reg),
    .cpu_data     (cpu_data),
    .cpu_full     (cpu_full),
    .cpu_overflow (cpu_overflow),
    .cpu_cursor   (cpu_cursor),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we)
  );

  always #5 clk = ~clk;

  // RAM model plus write and write-during-display counters
  always @(posedge clk) begin
    if (!model_init_r) begin
      for (int i = 0; i < 1200; i++) ram_model[i] <= 8'hEE;
      model_init_r <= 1'b1;
    end else if (ram_we === 1'b1) begin
      if (ram_addr < 11'd1200) ram_model[ram_addr] <= ram_din;
      wr_count <= wr_count + 1;
      if (display_on) disp_viol <= disp_viol + 1;
    end
  end

  task automatic set_pos(input int h, input int v);
    hpos = 10'(h);
    vpos = 10'(v);
    display_on = (h < 640) && (v < 480);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (hpos == 10'd799) set_pos(0, (vpos == 10'd524) ? 0 : int'(vpos) + 1);
    else set_pos(int'(hpos) + 1, int'(vpos));
  endtask

  task automatic cpu_write(input logic [1:0] r, input logic [7:0] d);
    cpu_wr = 1'b1;
    cpu_reg = r;
    cpu_data = d;
    adv();
    cpu_wr = 1'b0;
  endtask

  task automatic run_to(input int h);
    int n = 0;
    while (hpos != 10'(h) && n < 2000) begin
      adv();
      n++;
    end
    checks++;
    if (hpos != 10'(h)) begin
      errors++;
      $display("FAIL run_to: hpos %0d, wanted %0d", hpos, h);
    end
  endtask

  task automatic test_reset();
    set_pos(700, 0);
    repeat (3) adv();
    checks++; if (ram_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", ram_addr); end
    checks++; if (ram_din !== 8'd0) begin errors++; $display("FAIL reset_din: got %0h expected 0", ram_din); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", ram_we); end
    checks++; if (cpu_cursor !== 11'd0) begin errors++; $display("FAIL reset_cursor: got %0d expected 0", cpu_cursor); end
    checks++; if (cpu_full !== 1'b0 || cpu_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags: full %b ovf %b expected 0 0", cpu_full, cpu_overflow);
    end
    reset_n = 1'b1;
    adv();
  endtask

  task automatic test_cursor();
    set_pos(100, 10);
    cpu_write(R_HI, 8'd4);
    cpu_write(R_LO, 8'hAF);
    checks++; if (cpu_cursor !== 11'd1199) begin errors++; $display("FAIL cursor_set: got %0d expected 1199", cpu_cursor); end
    cpu_write(R_DATA, 8'h41);
    checks++; if (cpu_cursor !== 11'd0) begin errors++; $display("FAIL cursor_wrap: got %0d expected 0", cpu_cursor); end
    run_to(660);
    checks++; if (ram_model[1199] !== 8'h41) begin errors++; $display("FAIL cursor_ram1199: got %0h expected 41", ram_model[1199]); end
  endtask

  task automatic test_clamp();
    set_pos(100, 20);
    cpu_write(R_LO, 8'hFF);
    checks++; if (cpu_cursor !== 11'd255) begin errors++; $display("FAIL clamp_lo: got %0d expected 255", cpu_cursor); end
    cpu_write(R_HI, 8'd7);
    checks++; if (cpu_cursor !== 11'd0) begin errors++; $display("FAIL clamp_hi: got %0d expected 0", cpu_cursor); end
    cpu_write(R_DATA, 8'h42);
    cpu_write(R_RSVD, 8'h55);
    checks++; if (cpu_cursor !== 11'd1) begin errors++; $display("FAIL clamp_rsvd: got %0d expected 1", cpu_cursor); end
    run_to(660);
    checks++; if (ram_model[0] !== 8'h42) begin errors++; $display("FAIL clamp_ram0: got %0h expected 42", ram_model[0]); end
  endtask

  task automatic test_overflow();
    set_pos(100, 30);
    cpu_write(R_LO, 8'd0);
    cpu_write(R_HI, 8'd0);
    for (int i = 0; i < 5; i++) begin
      cpu_write(R_DATA, 8'h10 + 8'(i));
      if (i == 2) begin
        checks++; if (cpu_full !== 1'b0) begin errors++; $display("FAIL ovf_full3: got %b expected 0", cpu_full); end
      end
      if (i == 3) begin
        checks++; if (cpu_full !== 1'b1) begin errors++; $display("FAIL ovf_full4: got %b expected 1", cpu_full); end
        checks++; if (cpu_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", cpu_overflow); end
      end
    end
    checks++; if (cpu_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", cpu_overflow); end
    checks++; if (cpu_cursor !== 11'd4) begin errors++; $display("FAIL ovf_cursor: got %0d expected 4", cpu_cursor); end
    run_to(700);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram_model[i] !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL ovf_ram%0d: got %0h expected %0h", i, ram_model[i], 8'h10 + 8'(i));
      end
    end
    checks++; if (ram_model[4] !== 8'hEE) begin errors++; $display("FAIL ovf_dropped: got %0h expected ee", ram_model[4]); end
    checks++; if (cpu_full !== 1'b0 || cpu_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_after: full %b ovf %b expected 0 1", cpu_full, cpu_overflow);
    end
  endtask

  task automatic test_fetch();
    int wc0;
    set_pos(100, 36);
    cpu_write(R_HI, 8'd1);
    cpu_write(R_LO, 8'hF4);
    cpu_write(R_DATA, 8'h5A);
    wc0 = wr_count;
    set_pos(208, 37);
    adv();
    checks++; if (ram_addr !== 11'd93) begin errors++; $display("FAIL fetch_addr: got %0d expected 93", ram_addr); end
    for (int i = 0; i < 15; i++) begin
      adv();
      checks++; if (ram_addr !== 11'd93) begin errors++; $display("FAIL fetch_hold: hpos %0d got %0d expected 93", hpos, ram_addr); end
    end
    adv();
    checks++; if (ram_addr !== 11'd94) begin errors++; $display("FAIL fetch_next: got %0d expected 94", ram_addr); end
    run_to(639);
    checks++; if (wr_count !== wc0 || ram_we !== 1'b0) begin errors++; $display("FAIL fetch_nowrite: writes %0d expected %0d", wr_count, wc0); end
    run_to(660);
    checks++; if (ram_model[500] !== 8'h5A) begin errors++; $display("FAIL fetch_drain: got %0h expected 5a", ram_model[500]); end
    checks++; if (ram_addr !== 11'd500) begin errors++; $display("FAIL blank_addr_hold: got %0d expected 500", ram_addr); end
  endtask

  task automatic test_guard();
    int wc0;
    set_pos(796, 50);
    cpu_write(R_DATA, 8'h77);
    wc0 = wr_count;
    run_to(0);
    checks++; if (wr_count !== wc0) begin errors++; $display("FAIL guard_tail: writes %0d expected %0d", wr_count, wc0); end
    run_to(639);
    checks++; if (wr_count !== wc0) begin errors++; $display("FAIL guard_active: writes %0d expected %0d", wr_count, wc0); end
    run_to(660);
    checks++; if (ram_model[501] !== 8'h77 || wr_count !== wc0 + 1) begin
      errors++; $display("FAIL guard_drain: got %0h writes %0d expected 77 %0d", ram_model[501], wr_count, wc0 + 1);
    end
    set_pos(796, 500);
    cpu_write(R_DATA, 8'h78);
    run_to(0);
    checks++; if (ram_model[502] !== 8'hEE) begin errors++; $display("FAIL guard_vtail: got %0h expected ee", ram_model[502]); end
    run_to(10);
    checks++; if (ram_model[502] !== 8'h78) begin errors++; $display("FAIL guard_vblank: got %0h expected 78", ram_model[502]); end
    checks++; if (disp_viol !== 0) begin errors++; $display("FAIL guard_we_display: got %0d expected 0", disp_viol); end
  endtask

  task automatic test_reset_strobe();
    int wc0;
    int n = 0;
    set_pos(100, 60);
    cpu_write(R_HI, 8'd2);
    cpu_write(R_LO, 8'h58);
    checks++; if (cpu_cursor !== 11'd600) begin errors++; $display("FAIL rst_cursor_set: got %0d expected 600", cpu_cursor); end
    set_pos(700, 60);
    cpu_write(R_DATA, 8'hA0);
    cpu_write(R_DATA, 8'hA1);
    while (ram_we !== 1'b1 && n < 10) begin
      adv();
      n++;
    end
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rst_strobe_seen: got %b expected 1", ram_we); end
    checks++; if (cpu_overflow !== 1'b1) begin errors++; $display("FAIL rst_ovf_before: got %b expected 1", cpu_overflow); end
    wc0 = wr_count;
    reset_n = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we_async: got %b expected 0", ram_we); end
    checks++; if (cpu_cursor !== 11'd0 || ram_addr !== 11'd0) begin
      errors++; $display("FAIL rst_regs: cursor %0d addr %0d expected 0 0", cpu_cursor, ram_addr);
    end
    checks++; if (cpu_overflow !== 1'b0 || cpu_full !== 1'b0) begin
      errors++; $display("FAIL rst_flags: ovf %b full %b expected 0 0", cpu_overflow, cpu_full);
    end
    adv();
    adv();
    reset_n = 1'b1;
    repeat (300) adv();
    checks++; if (wr_count !== wc0) begin errors++; $display("FAIL rst_no_writes: writes %0d expected %0d", wr_count, wc0); end
    checks++; if (ram_model[601] !== 8'hEE) begin errors++; $display("FAIL rst_lost_entry: got %0h expected ee", ram_model[601]); end
    checks++; if (disp_viol !== 0) begin errors++; $display("FAIL rst_we_display: got %0d expected 0", disp_viol); end
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_clamp();
    test_overflow();
    test_fetch();
    test_guard();
    test_reset_strobe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
